// File: rtl/prio_arb_enc.sv
// -----------------------------------------------------------------------------
// prio_arb_enc -- registered N-input priority encoder / arbiter with a
// grant/acknowledge handshake.
//
// One winner is latched from the request bank and its encoded index and one-hot
// grant are held stable until the consumer acknowledges. The block then
// re-arbitrates in the same edge, with the just-served input excluded for that
// single decision. Winner selection is either fixed priority (highest index
// wins) or round-robin (descending search starting just below the last winner,
// with wrap-around).
//
// Parameters
//   N     number of request inputs (2..32)
//   W     encoded index width, derived from N (leave at its default)
//   MODE  0 = fixed priority, 1 = round-robin
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   req    request vector, sampled on clk
//   en     arbitration enable; gates new grants only
//   ack    consumer acknowledge of the current grant
//   y      encoded index of the granted request (holds last value when idle)
//   grant  one-hot grant, 1 << y while w=1, all-zero otherwise
//   w      grant valid
// -----------------------------------------------------------------------------
module prio_arb_enc #(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         ack,
  output logic [W-1:0] y,
  output logic [N-1:0] grant,
  output logic         w
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GNT  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   y_q, y_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [W-1:0]   ptr_q, ptr_d;

  logic [N-1:0]   eff;
  logic [W-1:0]   win;
  logic           load;

  // ---------------------------------------------------------------------------
  // Winner selection functions
  // ---------------------------------------------------------------------------

  // Highest set index. Later loop iterations override earlier ones, so the
  // last (highest) set bit is what remains.
  function automatic logic [W-1:0] pick_fixed(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = W'(i);
    end
    return r;
  endfunction

  // Round-robin: search order p-1, p-2, ..., p (mod N). Step k visits index
  // (p - k) mod N; iterating k from N down to 1 lets the closest candidate
  // (smallest k) override the others. The modulo is done by a single
  // conditional subtract so non-power-of-two N works.
  function automatic logic [W-1:0] pick_rr(input logic [N-1:0] v,
                                           input logic [W-1:0] p);
    logic [W-1:0] r;
    int           idx;
    r = '0;
    for (int k = N; k >= 1; k--) begin
      idx = int'(p) + N - k;
      if (idx >= N) idx = idx - N;
      if (v[idx]) r = W'(idx);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Effective request vector and winner
  // ---------------------------------------------------------------------------

  // grant_q is all-zero in IDLE, so the same mask serves both states: in IDLE
  // it is the raw request vector, in GNT the current winner is excluded for
  // the re-arbitration decision taken on an ack edge.
  always_comb begin
    eff = req & ~grant_q;
    if (MODE == 1) begin
      win = pick_rr(eff, ptr_q);
    end else begin
      win = pick_fixed(eff);
    end
  end

  // ---------------------------------------------------------------------------
  // State register (also holds the output and pointer registers)
  // ---------------------------------------------------------------------------

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of
  // process ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // NOTE: every signal written here gets a default at the top so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // ack is ignored here; only en and a non-empty request matter.
        if (en && (|eff)) begin
          state_d = S_GNT;
          load    = 1'b1;
        end
      end
      S_GNT: begin
        // Without ack everything is held, whatever req/en do.
        if (ack) begin
          if (en && (|eff)) begin
            load = 1'b1;          // back-to-back grant, no idle cycle
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Datapath next values follow the state decision.
    y_d     = y_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    if (load) begin
      y_d     = win;
      ptr_d   = win;              // last winner becomes lowest priority
      grant_d = N'(1) << win;
    end else if (state_d == S_IDLE) begin
      grant_d = '0;               // y keeps its last value, grant clears
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: straight from registers, so all three are glitch-free and cleared
  // immediately by the asynchronous reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    w     = (state_q == S_GNT);
    y     = y_q;
    grant = grant_q;
  end

endmodule

// File: doc/prio_arb_enc.md
# prio_arb_enc

Parametrised, registered successor to the 4:2 priority coder: an N-input priority encoder with a grant/acknowledge handshake and a selectable fixed-priority or round-robin mode. It sits between a bank of N request lines and a single shared resource. It latches one winner, holds its encoded index and a one-hot grant stable until the consumer acknowledges, then re-arbitrates. With MODE=0 and N=4 its encoding matches the 4:2 coder: highest index wins, and `w` marks a valid result.

## Interface
- `N`, 8: number of request inputs, 2..32.
- `W`, $clog2(N): width of the encoded index. This is derived and must not be overridden.
- `MODE`, 0: 0 = fixed priority (highest index wins); 1 = round-robin.
- `clk`  input  1  rising-edge clock. This is the block's only clock.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `req`  input  N  request vector, sampled on `clk`.
- `en`  input  1  arbitration enable. It gates new grants only.
- `ack`  input  1  consumer acknowledge of the current grant.
- `y`  output  W  encoded index of the granted request (registered).
- `grant`  output  N  one-hot grant, equal to `1 << y` while `w`=1 and all-zero otherwise (registered).
- `w`  output  1  grant valid (registered).

## Operation
- The FSM has two states:
  - IDLE: `w`=0, `grant`=0.
  - GNT: `w`=1, and `y`/`grant` hold the winner.
- Reset state:
  - State is IDLE.
  - `y`=0, `grant`=0, `w`=0.
  - Round-robin pointer `ptr`=0.
- IDLE → GNT happens on a clock edge where `en`=1 and `req`≠0. The winner is computed from `req` at that edge.
- In IDLE with `en`=0 or `req`=0, the block stays in IDLE and `y` holds its last value.
- GNT with `ack`=0:
  - State stays GNT.
  - `y`, `grant` and `w` are held stable, whatever `req` or `en` do. A winner that drops its `req` keeps its grant.
- GNT with `ack`=1, at that edge:
  - Re-arbitrate on the effective vector `req & ~grant`, so the just-served input is excluded for that one decision.
  - If the effective vector ≠0 and `en`=1, go to GNT with the new winner in the next cycle (back-to-back, no idle cycle).
  - Otherwise go to IDLE.
- Winner selection for MODE=0: the highest set index of the effective vector.
- Winner selection for MODE=1:
  - Search order is `ptr-1`, `ptr-2`, …, `ptr` (mod N), descending with wrap-around. The first set bit wins.
  - At reset `ptr`=0, so the order is N-1…0, identical to fixed priority.
- Pointer update:
  - `ptr` is loaded with the winner index on every entry to GNT, so the last winner becomes lowest priority.
  - `ptr` is unused in MODE=0 but still updates.
- `ack` in IDLE is ignored.

## Timing
- Latency is 1 cycle: `req`/`en` valid before edge k gives `w`, `y` and `grant` valid after edge k.
- Handshake: a transfer completes on any edge where `w`=1 and `ack`=1. `ack` may be held high permanently.
- Throughput is one grant per cycle when `ack` is held high and multiple requests are pending.
- Simultaneous events:
  - A request arriving in the same cycle as `ack` is included in the re-arbitration.
  - The acked input's own `req` is masked for that edge only. If it is still high one edge later, it competes normally.
- Asynchronous reset mid-grant: `w`, `grant` and `y` go to 0 immediately (not on the clock edge), and `ptr` goes to 0. The first arbitration after `rst_n` deasserts behaves as from power-up.

## Test plan
- Reset: assert `rst_n`=0 while in GNT → `w`=0, `grant`=0 and `y`=0 without waiting for a clock edge. After release, with N=4, MODE=0, `req`=4'b0000 → `w` stays 0.
- Fixed-priority encode: N=4, MODE=0, `en`=1. Apply in turn `req`=0001, 0010, 0110 and 1011, with `ack` pulsed after each → `y`=0, 1, 2, 3 and `grant`=0001, 0010, 0100, 1000. Each result appears one cycle after `req` is applied.
- Hold and mask:
  - N=4. `req`=0100 gives `y`=2.
  - Change `req` to 1000 without `ack` → `y` stays 2.
  - Then apply `ack` with `req`=1100 → next cycle `y`=3 (index 2 was masked).
- Round-robin rotation: N=4, MODE=1, `req`=1111 held, `ack`=1 held → `y` sequence is 3, 2, 1, 0, 3… with `w`=1 on every cycle.
- Enable gating: `en`=0 with `req`=0101 → `w`=0 indefinitely. Raise `en` → `y`=2 after one edge. Drop `en` during GNT → the grant is held until `ack`, then the block goes to IDLE.
- Wide parameter: N=32, MODE=0, `req`=bit 31 | bit 0 → `y`=31, `grant`=32'h8000_0000. After `ack`, `y`=0.
